// File: rtl/psr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : psr_pkg
//  Purpose  : Shared mode codes, FSM state encoding and helpers for the
//             parametrised universal shift register.
//  Revision : 1.0  initial release
// ============================================================================
package psr_pkg;

    // Operation codes applied for one step (or latched for a burst)
    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_SHL  = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_ROL  = 3'd5;
    localparam logic [2:0] MODE_ASR  = 3'd6;
    localparam logic [2:0] MODE_RSVD = 3'd7;

    // Burst engine state
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } psr_state_t;

    // Only the shift/rotate codes can be repeated as a burst
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m >= MODE_SHR) && (m <= MODE_ASR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/psr_step.sv
`default_nettype none
// ============================================================================
//  Module   : psr_step
//  Purpose  : Combinational single-step shift/rotate unit. Returns the value
//             the register takes after one step of the given mode. Codes
//             that do not move bits (HOLD, LOAD, reserved) return the input.
//  Revision : 1.0  initial release
// ============================================================================
module psr_step
    import psr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [2:0]       i_mode,
    input  logic             i_ser_in_r,
    input  logic             i_ser_in_l,
    output logic [WIDTH-1:0] o_q_next
);

    // Select one-bit move by mode; default passes the value through
    always_comb begin
        o_q_next = i_q;
        case (i_mode)
            MODE_SHR: o_q_next = {i_ser_in_r, i_q[WIDTH-1:1]};
            MODE_SHL: o_q_next = {i_q[WIDTH-2:0], i_ser_in_l};
            MODE_ROR: o_q_next = {i_q[0], i_q[WIDTH-1:1]};
            MODE_ROL: o_q_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            MODE_ASR: o_q_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
            default:  o_q_next = i_q;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/param_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : param_shift_reg
//  Purpose  : WIDTH-bit universal register (hold/load/shift/rotate/ASR) with
//             clock enable, complementary outputs and a multi-step burst
//             engine driven by start/shamt with busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module param_shift_reg
    import psr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             sync_reset_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic             start,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);

    localparam logic [SHW-1:0] C_CNT_ZERO = '0;
    localparam logic [SHW-1:0] C_CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    psr_state_t       r_state;
    psr_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [SHW-1:0]   r_cnt;
    logic [SHW-1:0]   w_cnt_nxt;
    logic [2:0]       r_mode;
    logic [2:0]       w_mode_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [2:0]       w_step_mode;
    logic [WIDTH-1:0] w_step_q;

    // While bursting the latched mode drives the step unit; otherwise the live one
    assign w_step_mode = (r_state == ST_BUSY) ? r_mode : mode;

    psr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_q        (r_q),
        .i_mode     (w_step_mode),
        .i_ser_in_r (ser_in_r),
        .i_ser_in_l (ser_in_l),
        .o_q_next   (w_step_q)
    );

    // Next-state, next-value and done-pulse decode; en low freezes everything
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (start && is_shift_mode(mode)) begin
                        // Register holds on the start edge; the burst steps follow
                        if (shamt != C_CNT_ZERO) begin
                            w_state_nxt = ST_BUSY;
                            w_mode_nxt  = mode;
                            w_cnt_nxt   = shamt;
                        end else begin
                            w_done_nxt  = 1'b1;
                        end
                    end else if (mode == MODE_LOAD) begin
                        w_q_nxt = D;
                    end else begin
                        w_q_nxt = w_step_q;
                    end
                end
                ST_BUSY: begin
                    w_q_nxt   = w_step_q;
                    w_cnt_nxt = r_cnt - C_CNT_ONE;
                    if (r_cnt == C_CNT_ONE) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_HOLD;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign Q         = r_q;
    assign Qb        = ~r_q;
    assign ser_out_r = r_q[0];
    assign ser_out_l = r_q[WIDTH-1];
    assign busy      = (r_state == ST_BUSY);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_param_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_shift_reg
//  Purpose  : Directed self-checking bench for param_shift_reg (WIDTH=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_shift_reg;

    localparam int WIDTH = 8;
    localparam int SHW   = $clog2(WIDTH) + 1;

    logic             clk;
    logic             sync_reset_n;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             ser_in_r;
    logic             ser_in_l;
    logic             start;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             ser_out_r;
    logic             ser_out_l;
    logic             busy;
    logic             done;

    int n_total = 0;
    int n_bad   = 0;

    param_shift_reg #(
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .sync_reset_n (sync_reset_n),
        .en           (en),
        .mode         (mode),
        .D            (d),
        .ser_in_r     (ser_in_r),
        .ser_in_l     (ser_in_l),
        .start        (start),
        .shamt        (shamt),
        .Q            (q),
        .Qb           (qb),
        .ser_out_r    (ser_out_r),
        .ser_out_l    (ser_out_l),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One active edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_q(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        chk({tag, ".q"},    32'(q),    32'(eq));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        sync_reset_n = 1'b0; en = 1'b0; mode = 3'd0; d = '0;
        ser_in_r = 1'b0; ser_in_l = 1'b0; start = 1'b0; shamt = '0;

        // 1. reset and load
        tick(); tick();
        chk_q("rst", 8'h00, 1'b0, 1'b0);
        chk("rst.qb", 32'(qb), 32'hFF);
        sync_reset_n = 1'b1; en = 1'b1; mode = 3'd1; d = 8'hA5;
        tick();
        chk("load.q", 32'(q), 32'hA5);
        chk("load.qb", 32'(qb), 32'h5A);
        chk("load.sor", 32'(ser_out_r), 32'h1);
        chk("load.sol", 32'(ser_out_l), 32'h1);

        // 2. single steps
        mode = 3'd2; ser_in_r = 1'b1; tick(); chk("shr", 32'(q), 32'hD2);
        mode = 3'd3; ser_in_l = 1'b0; tick(); chk("shl", 32'(q), 32'hA4);
        mode = 3'd6; tick(); chk("asr", 32'(q), 32'hD2);
        mode = 3'd5; tick(); chk("rol", 32'(q), 32'hA5);
        en = 1'b0; mode = 3'd1; d = 8'hFF; tick(); chk("en0", 32'(q), 32'hA5);
        mode = 3'd7; en = 1'b1; tick(); chk("rsvd", 32'(q), 32'hA5);

        // 3. burst rotate right by 3
        mode = 3'd1; d = 8'h81; tick();
        mode = 3'd4; start = 1'b1; shamt = 4'd3; tick();
        chk_q("ror.s", 8'h81, 1'b1, 1'b0);
        start = 1'b0; mode = 3'd0;
        tick(); chk_q("ror.1", 8'hC0, 1'b1, 1'b0);
        tick(); chk_q("ror.2", 8'h60, 1'b1, 1'b0);
        tick(); chk_q("ror.3", 8'h30, 1'b0, 1'b1);
        tick(); chk_q("ror.4", 8'h30, 1'b0, 1'b0);

        // 4. burst with en gaps and ignored inputs
        mode = 3'd1; d = 8'h01; tick();
        mode = 3'd3; ser_in_l = 1'b0; start = 1'b1; shamt = 4'd4; tick();
        chk_q("shl.s", 8'h01, 1'b1, 1'b0);
        mode = 3'd1; d = 8'hFF; shamt = 4'd1;
        tick(); chk_q("shl.1", 8'h02, 1'b1, 1'b0);
        en = 1'b0;
        tick(); chk_q("shl.g1", 8'h02, 1'b1, 1'b0);
        tick(); chk_q("shl.g2", 8'h02, 1'b1, 1'b0);
        en = 1'b1;
        tick(); chk_q("shl.2", 8'h04, 1'b1, 1'b0);
        tick(); chk_q("shl.3", 8'h08, 1'b1, 1'b0);
        mode = 3'd0; start = 1'b0;
        tick(); chk_q("shl.4", 8'h10, 1'b0, 1'b1);

        // 5. boundaries: zero shamt, start with LOAD, long ASR
        mode = 3'd2; start = 1'b1; shamt = 4'd0; tick();
        chk_q("z.0", 8'h10, 1'b0, 1'b1);
        start = 1'b0; mode = 3'd0; tick();
        chk_q("z.1", 8'h10, 1'b0, 1'b0);
        mode = 3'd1; d = 8'h3C; start = 1'b1; shamt = 4'd5; tick();
        chk_q("sl.0", 8'h3C, 1'b0, 1'b0);
        start = 1'b0; mode = 3'd0; tick();
        chk_q("sl.1", 8'h3C, 1'b0, 1'b0);
        mode = 3'd1; d = 8'h80; tick();
        mode = 3'd6; start = 1'b1; shamt = 4'd9; tick();
        start = 1'b0; mode = 3'd0;
        for (int i = 0; i < 8; i++) tick();
        chk_q("asr9.8", 8'hFF, 1'b1, 1'b0);
        tick(); chk_q("asr9.9", 8'hFF, 1'b0, 1'b1);

        // 6. reset mid-burst, then a fresh burst
        mode = 3'd1; d = 8'h55; tick();
        mode = 3'd2; ser_in_r = 1'b0; start = 1'b1; shamt = 4'd5; tick();
        start = 1'b0; mode = 3'd0;
        tick(); chk_q("ab.1", 8'h2A, 1'b1, 1'b0);
        sync_reset_n = 1'b0; tick();
        chk_q("ab.r", 8'h00, 1'b0, 1'b0);
        sync_reset_n = 1'b1; tick();
        chk_q("ab.n", 8'h00, 1'b0, 1'b0);
        mode = 3'd1; d = 8'h0F; tick();
        mode = 3'd5; start = 1'b1; shamt = 4'd2; tick();
        start = 1'b0; mode = 3'd0;
        tick(); chk_q("nb.1", 8'h1E, 1'b1, 1'b0);
        tick(); chk_q("nb.2", 8'h3C, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
